multicycle_controller: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath (R-type, ADDI, SLTI, ANDI, ORI, XORI). It walks each instruction through FETCH, DECODE, EXEC and WB states, and issues the IR/PC/register-file strobes plus the registered datapath controls (reg_dst, alu_src, alu_op). It runs a fixed-length program segment of PROG_LEN instructions per start request, counts retired instructions, and aborts on an unsupported opcode.

---
 rtl/multicycle_controller_if.sv | 49 ++++
 rtl/multicycle_controller.sv | 166 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Groups the run handshake, the instruction opcode and every strobe/control
// produced by the multi-cycle sequencer.
//
//   start        host -> ctrl  run request (only looked at while idle)
//   opcode       host -> ctrl  instr[31:26] from the IR
//   ir_write     ctrl -> host  load IR from instruction memory
//   pc_write     ctrl -> host  PC <- PC + 4
//   reg_write    ctrl -> host  register-file write enable
//   reg_dst      ctrl -> host  1 = rd, 0 = rt
//   alu_src      ctrl -> host  1 = extended immediate, 0 = rt
//   alu_op       ctrl -> host  ALU operation class
//   busy         ctrl -> host  sequencer not idle
//   done         ctrl -> host  one-cycle completion pulse
//   illegal      ctrl -> host  sticky unsupported-opcode flag
//   instr_count  ctrl -> host  retired instructions in current/last run
//
// master: the datapath/host side.  slave: the controller.
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [5:0]       opcode;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, opcode,
    input  ir_write, pc_write, reg_write, reg_dst, alu_src, alu_op,
           busy, done, illegal, instr_count
  );

  modport slave (
    input  start, opcode,
    output ir_write, pc_write, reg_write, reg_dst, alu_src, alu_op,
           busy, done, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle sequencer for a MIPS-subset datapath (R-type, ADDI, SLTI, ANDI,
// ORI, XORI).  Each instruction walks FETCH -> DECODE -> EXEC -> WB.  A run of
// PROG_LEN instructions is launched by start while idle; an unsupported opcode
// seen in DECODE aborts the run and raises the sticky illegal flag.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   multicycle_controller_if.slave (start/opcode in, strobes,
//         decoded controls, status and instr_count out)
//
// Parameters:
//   PROG_LEN  instructions retired per run (>= 1)
//   CNT_W     width of instr_count (2**CNT_W > PROG_LEN)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int PROG_LEN = 16,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [CNT_W:0] LEN_C = (CNT_W+1)'(PROG_LEN);

  state_t           state_reg;
  state_t           state_next;

  logic             reg_dst_reg;
  logic             alu_src_reg;
  logic [1:0]       alu_op_reg;
  logic             done_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] count_reg;

  logic             dec_legal;
  logic             dec_reg_dst;
  logic             dec_alu_src;
  logic [1:0]       dec_alu_op;

  logic [CNT_W:0]   count_inc;
  logic             last_instr;
  logic             start_accept;

  // One extra bit so the compare cannot wrap when count_reg is at its max.
  assign count_inc    = {1'b0, count_reg} + (CNT_W+1)'(1);
  assign last_instr   = (count_inc >= LEN_C);
  assign start_accept = (state_reg == S_IDLE) && bus.start;

  // Opcode decode table.
  always_comb begin
    dec_legal   = 1'b1;
    dec_reg_dst = 1'b0;
    dec_alu_src = 1'b1;
    dec_alu_op  = 2'b00;
    case (bus.opcode)
      6'b000000: begin                 // R-type
        dec_reg_dst = 1'b1;
        dec_alu_src = 1'b0;
        dec_alu_op  = 2'b10;
      end
      6'b001000: dec_alu_op = 2'b00;   // ADDI
      6'b001010: dec_alu_op = 2'b01;   // SLTI
      6'b001100,                       // ANDI
      6'b001101,                       // ORI
      6'b001110: dec_alu_op = 2'b11;   // XORI
      default: begin
        dec_legal   = 1'b0;
        dec_alu_src = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = dec_legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = last_instr ? S_IDLE : S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore strobes, purely from the current state.
  always_comb begin
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.busy      = (state_reg != S_IDLE);
    case (state_reg)
      S_FETCH: bus.ir_write = 1'b1;
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered controls, completion pulse, sticky flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_dst_reg <= 1'b0;
      alu_src_reg <= 1'b0;
      alu_op_reg  <= 2'b00;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      // done lands in the first IDLE cycle after the final WB or an abort.
      done_reg <= ((state_reg == S_WB) && last_instr) ||
                  ((state_reg == S_DECODE) && !dec_legal);

      if (start_accept) begin
        count_reg   <= '0;
        illegal_reg <= 1'b0;
      end else begin
        if (state_reg == S_WB) begin
          count_reg <= count_reg + CNT_W'(1);
        end
        if ((state_reg == S_DECODE) && !dec_legal) begin
          illegal_reg <= 1'b1;
        end
      end

      // An illegal opcode leaves the previous instruction's controls in place.
      if ((state_reg == S_DECODE) && dec_legal) begin
        reg_dst_reg <= dec_reg_dst;
        alu_src_reg <= dec_alu_src;
        alu_op_reg  <= dec_alu_op;
      end
    end
  end

  assign bus.reg_dst     = reg_dst_reg;
  assign bus.alu_src     = alu_src_reg;
  assign bus.alu_op      = alu_op_reg;
  assign bus.done        = done_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Four controllers (PROG_LEN = 2, 6, 4, 1) share one clock and reset.  Each
// run's expected per-cycle outputs are derived from the program alone: cycle
// number -> instruction index and phase, done/abort cycle from the first
// illegal opcode, decoded controls from the opcode table.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [7:0] instr_count;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_v [4];
  logic [5:0]  op_v    [4];
  obs_t [3:0]  obs;

  logic [5:0]  prog_a    [16];
  logic [3:0]  model_dec [4];   // {reg_dst, alu_src, alu_op} held per DUT

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int len_of(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 6 : (idx == 2) ? 4 : 1;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int LEN = (gi == 0) ? 2 : (gi == 1) ? 6 : (gi == 2) ? 4 : 1;
    multicycle_controller_if #(.CNT_W(8)) bus ();
    assign bus.start  = start_v[gi];
    assign bus.opcode = op_v[gi];
    assign obs[gi] = {bus.ir_write, bus.pc_write, bus.reg_write, bus.reg_dst,
                      bus.alu_src, bus.alu_op, bus.busy, bus.done,
                      bus.illegal, bus.instr_count};
    multicycle_controller #(.PROG_LEN(LEN), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // Opcode table: {legal, reg_dst, alu_src, alu_op}.
  function automatic logic [4:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return 5'b1_1_0_10;
      6'b001000: return 5'b1_0_1_00;
      6'b001010: return 5'b1_0_1_01;
      6'b001100, 6'b001101, 6'b001110: return 5'b1_0_1_11;
      default:   return 5'b0_0_0_00;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic [4:0] d;
    d = ref_decode(op);
    return d[4];
  endfunction

  // Controls in force once n instructions of the program have been decoded.
  function automatic logic [3:0] dec_before(input int n, input logic [3:0] dec0);
    logic [4:0] d;
    if (n == 0) return dec0;
    d = ref_decode(prog_a[n-1]);
    return d[3:0];
  endfunction

  // Expected outputs in cycle c of a run (cycle 0 = start sampled).
  function automatic obs_t model_cycle(input int c, input int plen, input int fi,
                                       input int d, input logic [3:0] dec0,
                                       input bit after);
    obs_t e;
    int k, ph, fin;
    logic [3:0] dv;
    e = '0;
    if (c >= d) begin
      fin           = (fi < plen) ? fi : plen;
      dv            = dec_before(fin, dec0);
      e.done        = !after;
      e.illegal     = (fi < plen);
      e.instr_count = 8'(fin);
    end else begin
      k             = (c - 1) / 4;
      ph            = (c - 1) % 4;
      dv            = (ph >= 2) ? dec_before(k + 1, dec0) : dec_before(k, dec0);
      e.busy        = 1'b1;
      e.ir_write    = (ph == 0);
      e.reg_write   = (ph == 3);
      e.pc_write    = (ph == 3);
      e.instr_count = 8'(k);
    end
    {e.reg_dst, e.alu_src, e.alu_op} = dv;
    return e;
  endfunction

  function automatic logic [5:0] rand_legal();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return 6'b000000;
      1: return 6'b001000;
      2: return 6'b001010;
      3: return 6'b001100;
      4: return 6'b001101;
      default: return 6'b001110;
    endcase
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    for (int t = 0; t < 64; t++) begin
      op = 6'($urandom);
      if (!is_legal(op)) return op;
    end
    return 6'b100011;
  endfunction

  // Runs prog_a on DUT idx; called just after a negedge (cycle 0).
  // mode: 0 start low while busy, 1 held high, 2 random.
  // chain: leave the done cycle for the next call to restart in.
  // abort_c: if > 0, return right after checking that cycle.
  task automatic run_prog(input string name, input int idx, input int mode,
                          input bit chain, input int abort_c);
    int plen, fi, d;
    logic [3:0] dec0;
    obs_t e;
    plen = len_of(idx);
    fi   = plen;
    for (int k = plen - 1; k >= 0; k--) begin
      if (!is_legal(prog_a[k])) fi = k;
    end
    d    = (fi < plen) ? 4 * fi + 3 : 4 * plen + 1;
    dec0 = model_dec[idx];
    start_v[idx] = 1'b1;
    op_v[idx]    = 6'($urandom);
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      e = model_cycle(c, plen, fi, d, dec0, 1'b0);
      n_cmp++;
      if (obs[idx] !== e) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, idx, c, obs[idx], e);
      end
      if (c == abort_c) return;
      if (c < d) begin
        start_v[idx] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        op_v[idx]    = (c % 4 == 2) ? prog_a[(c - 1) / 4] : 6'($urandom);
      end
    end
    model_dec[idx] = dec_before((fi < plen) ? fi : plen, dec0);
    $display("run %s dut%0d len=%0d end_cycle=%0d illegal_at=%0d", name, idx, plen, d, fi);
    if (!chain) begin
      start_v[idx] = 1'b0;
      @(negedge clk);
      e = model_cycle(d + 1, plen, fi, d, dec0, 1'b1);
      n_cmp++;
      if (obs[idx] !== e) begin
        n_fail++;
        $display("FAIL %s_idle dut%0d: got %h expected %h", name, idx, obs[idx], e);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %h expected 0", i, obs[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[i] !== '0) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cycle %0d: got %h expected 0", i, c, obs[i]);
        end
      end
    end
    $display("reset: all outputs checked zero");
  endtask

  task automatic test_two_instr();
    prog_a[0] = 6'b001000;
    prog_a[1] = 6'b000000;
    run_prog("two_instr", 0, 0, 1'b0, 0);
  endtask

  task automatic test_opcode_sweep();
    prog_a[0] = 6'b001010;
    prog_a[1] = 6'b001100;
    prog_a[2] = 6'b001101;
    prog_a[3] = 6'b001110;
    prog_a[4] = 6'b001000;
    prog_a[5] = 6'b000000;
    run_prog("sweep", 1, 0, 1'b0, 0);
  endtask

  task automatic test_illegal();
    prog_a[0] = rand_legal();
    prog_a[1] = 6'b100011;
    prog_a[2] = rand_legal();
    prog_a[3] = rand_legal();
    run_prog("illegal", 2, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    prog_a[0] = 6'b001101;
    prog_a[1] = rand_illegal();
    prog_a[2] = rand_legal();
    prog_a[3] = rand_legal();
    run_prog("held_start", 2, 1, 1'b1, 0);
    for (int k = 0; k < 4; k++) prog_a[k] = rand_legal();
    run_prog("back_to_back", 2, 0, 1'b0, 0);
  endtask

  task automatic test_prog_len_one();
    prog_a[0] = 6'b001010;
    run_prog("len_one", 3, 2, 1'b0, 0);
  endtask

  task automatic test_rst_mid_run();
    for (int k = 0; k < 6; k++) prog_a[k] = rand_legal();
    run_prog("rst_mid", 1, 0, 1'b0, 3);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs[i] !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_async dut%0d: got %h expected 0", i, obs[i]);
      end
      model_dec[i] = 4'b0000;
    end
    @(negedge clk);
    rst = 1'b0;
    start_v[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs[1] !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_idle cycle %0d: got %h expected 0", c, obs[1]);
      end
    end
    $display("rst_mid: aborted in EXEC, idle with no done");
    run_prog("after_rst", 1, 2, 1'b0, 0);
  endtask

  task automatic test_random();
    int idx, mode;
    bit chain;
    idx = 0;
    for (int r = 0; r < 24; r++) begin
      if (!chain) idx = $urandom_range(0, 3);
      mode  = $urandom_range(0, 2);
      chain = (r < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int k = 0; k < 16; k++) begin
        prog_a[k] = ($urandom_range(0, 7) == 0) ? rand_illegal() : rand_legal();
      end
      run_prog("random", idx, mode, chain, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_v[i]   = 1'b0;
      op_v[i]      = 6'b000000;
      model_dec[i] = 4'b0000;
    end
    for (int k = 0; k < 16; k++) prog_a[k] = 6'b000000;

    test_reset();
    test_two_instr();
    test_opcode_sweep();
    test_illegal();
    test_back_to_back();
    test_prog_len_one();
    test_rst_mid_run();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
